// File: rtl/arp_arb_pkg.sv
// Shared types and widths for the ARP request arbiter: FSM state encoding and
// the IP/MAC field widths of the ARP core lookup interface.
package arp_arb_pkg;

    localparam int ARP_IP_W  = 32;
    localparam int ARP_MAC_W = 48;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/arp_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping past N_REQ-1 back to 0 (explicit modulo, so any N_REQ works).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        // Walk offsets from farthest to nearest so the nearest hit is the last write.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arp_req_arbiter.sv
// Round-robin arbiter sharing one ARP core lookup port among N_REQ requesters,
// one lookup outstanding. Optional response timeout: define ARP_ARB_TIMEOUT_EN.
module arp_req_arbiter
    import arp_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           s_arp_request_valid,
    output logic [N_REQ-1:0]           s_arp_request_ready,
    input  logic [N_REQ*32-1:0]        s_arp_request_ip,
    output logic [N_REQ-1:0]           s_arp_response_valid,
    input  logic [N_REQ-1:0]           s_arp_response_ready,
    output logic                       s_arp_response_error,
    output logic [47:0]                s_arp_response_mac,
    output logic                       m_arp_request_valid,
    input  logic                       m_arp_request_ready,
    output logic [31:0]                m_arp_request_ip,
    input  logic                       m_arp_response_valid,
    output logic                       m_arp_response_ready,
    input  logic                       m_arp_response_error,
    input  logic [47:0]                m_arp_response_mac,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [ARP_IP_W-1:0]   ip_q, ip_d;
    logic [ARP_MAC_W-1:0]  mac_q, mac_d;
    logic                  err_q, err_d;
    logic                  grant_block;

    logic [N_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;

`ifdef ARP_ARB_TIMEOUT_EN
    logic [31:0]           cnt_q, cnt_d;
    logic                  drop_pend_q, drop_pend_d;

    // A timed-out lookup may still be answered; hold off new grants until
    // that stale answer has been swallowed.
    assign grant_block = drop_pend_q;
`else
    assign grant_block = 1'b0;

    // Timeout support is compiled out; the parameter is kept for a uniform interface.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (s_arp_request_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d              = state_q;
        rr_ptr_d             = rr_ptr_q;
        grant_idx_d          = grant_idx_q;
        ip_d                 = ip_q;
        mac_d                = mac_q;
        err_d                = err_q;
        s_arp_request_ready  = '0;
        s_arp_response_valid = '0;
        m_arp_request_valid  = 1'b0;
        m_arp_response_ready = 1'b0;
`ifdef ARP_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        drop_pend_d = drop_pend_q;
        if (drop_pend_q) begin
            m_arp_response_ready = 1'b1;
            if (m_arp_response_valid) begin
                drop_pend_d = 1'b0;
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (pick_found && !grant_block) begin
                    s_arp_request_ready = pick_onehot;
                    ip_d                = s_arp_request_ip[pick_idx*ARP_IP_W +: ARP_IP_W];
                    grant_idx_d         = pick_idx;
                    state_d             = REQ;
                end
            end
            REQ: begin
                m_arp_request_valid = 1'b1;
                if (m_arp_request_ready) begin
                    state_d = WAIT;
`ifdef ARP_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                m_arp_response_ready = 1'b1;
                if (m_arp_response_valid) begin
                    mac_d   = m_arp_response_mac;
                    err_d   = m_arp_response_error;
                    state_d = RESP;
                end
`ifdef ARP_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_d == 32'(TIMEOUT_CYCLES)) begin
                        mac_d       = '0;
                        err_d       = 1'b1;
                        drop_pend_d = 1'b1;
                        state_d     = RESP;
                    end
                end
`endif
            end
            RESP: begin
                s_arp_response_valid[grant_idx_q] = 1'b1;
                if (s_arp_response_ready[grant_idx_q]) begin
                    rr_ptr_d = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                                  : grant_idx_q + IDX_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            err_q       <= 1'b0;
`ifdef ARP_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            drop_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            ip_q        <= ip_d;
            mac_q       <= mac_d;
            err_q       <= err_d;
`ifdef ARP_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            drop_pend_q <= drop_pend_d;
`endif
        end
    end

    assign m_arp_request_ip     = ip_q;
    assign s_arp_response_mac   = mac_q;
    assign s_arp_response_error = err_q;
    assign grant_idx            = grant_idx_q;

endmodule

// File: tb/tb_arp_req_arbiter.sv
// Self-checking bench for arp_req_arbiter: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_arp_req_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_arp_request_valid;
    logic [N-1:0]    s_arp_request_ready;
    logic [N*32-1:0] s_arp_request_ip;
    logic [N-1:0]    s_arp_response_valid;
    logic [N-1:0]    s_arp_response_ready;
    logic            s_arp_response_error;
    logic [47:0]     s_arp_response_mac;
    logic            m_arp_request_valid;
    logic            m_arp_request_ready;
    logic [31:0]     m_arp_request_ip;
    logic            m_arp_response_valid;
    logic            m_arp_response_ready;
    logic            m_arp_response_error;
    logic [47:0]     m_arp_response_mac;
    logic [1:0]      grant_idx;

    always #5 clk = ~clk;

    arp_req_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_arp_request_valid  (s_arp_request_valid),
        .s_arp_request_ready  (s_arp_request_ready),
        .s_arp_request_ip     (s_arp_request_ip),
        .s_arp_response_valid (s_arp_response_valid),
        .s_arp_response_ready (s_arp_response_ready),
        .s_arp_response_error (s_arp_response_error),
        .s_arp_response_mac   (s_arp_response_mac),
        .m_arp_request_valid  (m_arp_request_valid),
        .m_arp_request_ready  (m_arp_request_ready),
        .m_arp_request_ip     (m_arp_request_ip),
        .m_arp_response_valid (m_arp_response_valid),
        .m_arp_response_ready (m_arp_response_ready),
        .m_arp_response_error (m_arp_response_error),
        .m_arp_response_mac   (m_arp_response_mac),
        .grant_idx            (grant_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;
    int cyc     = 0;

    // stimulus knobs
    bit          rand_mode    = 0;
    int          core_delay   = 3;
    int          core_stall   = 0;
    bit          core_fix_mac = 0;
    logic [47:0] core_mac_val = '0;
    int          rsp_hold[N];
    bit          pend_req[N];
    logic [31:0] pend_ip[N];

    // observation logs
    logic [31:0]  req_log[$];
    logic [N-1:0] rsp_vec_log[$];
    logic [47:0]  rsp_mac_log[$];
    logic         rsp_err_log[$];
    int           core_rsp_cyc = 0;
    int           svalid_rise_cyc = 0;
    logic [N-1:0] prev_svalid = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (rr + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: one lookup record (owner, ip, sent to core, answered).
    bit          m_busy, m_sent, m_ans, m_err;
    int          m_owner, m_rr;
    logic [31:0] m_ip;
    logic [47:0] m_mac;

    always @(posedge clk) begin : model_upd
        int w;
        w = pick(s_arp_request_valid, m_rr);
        if (rst) begin
            m_busy <= 0; m_sent <= 0; m_ans <= 0; m_err <= 0;
            m_owner <= 0; m_rr <= 0; m_ip <= '0; m_mac <= '0;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_busy  <= 1;
                m_owner <= w;
                m_ip    <= s_arp_request_ip[w*32 +: 32];
            end
        end else if (!m_sent) begin
            if (m_arp_request_ready) m_sent <= 1;
        end else if (!m_ans) begin
            if (m_arp_response_valid) begin
                m_ans <= 1;
                m_mac <= m_arp_response_mac;
                m_err <= m_arp_response_error;
            end
        end else if (s_arp_response_ready[m_owner]) begin
            m_busy <= 0; m_sent <= 0; m_ans <= 0;
            m_rr   <= (m_owner + 1) % N;
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic [N-1:0] one, e_sready, e_svalid;
        one = 1;
        w = pick(s_arp_request_valid, m_rr);
        e_sready = (!m_busy && w >= 0) ? (one << w) : '0;
        e_svalid = (m_busy && m_ans) ? (one << m_owner) : '0;
        if (cmp_en) begin
            chk("s_req_ready", s_arp_request_ready, e_sready);
            chk("s_rsp_valid", s_arp_response_valid, e_svalid);
            chk("m_req_valid", m_arp_request_valid, m_busy && !m_sent);
            chk("m_req_ip", m_arp_request_ip, m_ip);
            chk("m_rsp_ready", m_arp_response_ready, m_busy && m_sent && !m_ans);
            chk("s_rsp_mac", s_arp_response_mac, m_mac);
            chk("s_rsp_err", s_arp_response_error, m_err);
            chk("grant_idx", grant_idx, m_owner);
        end
    end

    always @(negedge clk) begin : monitor
        cyc++;
        if (!rst) begin
            if (m_arp_request_valid && m_arp_request_ready) req_log.push_back(m_arp_request_ip);
            if (m_arp_response_valid && m_arp_response_ready) core_rsp_cyc = cyc;
            if (s_arp_response_valid != 0 && prev_svalid == 0) svalid_rise_cyc = cyc;
            if ((s_arp_response_valid & s_arp_response_ready) != 0) begin
                rsp_vec_log.push_back(s_arp_response_valid);
                rsp_mac_log.push_back(s_arp_response_mac);
                rsp_err_log.push_back(s_arp_response_error);
            end
        end
        prev_svalid = s_arp_response_valid;
    end

    // ARP core stand-in
    initial begin : core
        logic [31:0] cip;
        int cnt;
        bit pending, acc_req, acc_rsp;
        m_arp_request_ready = 0; m_arp_response_valid = 0;
        m_arp_response_error = 0; m_arp_response_mac = '0;
        pending = 0; cnt = 0; cip = '0;
        forever begin
            @(negedge clk);
            acc_req = m_arp_request_valid && m_arp_request_ready;
            acc_rsp = m_arp_response_valid && m_arp_response_ready;
            if (acc_req) cip = m_arp_request_ip;
            @(posedge clk); #1;
            if (rst) begin
                pending = 0; m_arp_response_valid = 0; m_arp_request_ready = 0;
            end else begin
                if (acc_rsp) begin m_arp_response_valid = 0; pending = 0; end
                if (acc_req) begin
                    pending = 1;
                    cnt = (core_delay < 0) ? $urandom_range(0, 6) : core_delay;
                end
                if (m_arp_request_valid && core_stall > 0) begin
                    m_arp_request_ready = 0;
                    core_stall--;
                end else begin
                    m_arp_request_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
                if (pending && !m_arp_response_valid) begin
                    if (cnt == 0) begin
                        m_arp_response_valid = 1;
                        m_arp_response_mac   = core_fix_mac ? core_mac_val : {16'h0200, cip};
                        m_arp_response_error = (cip[7:0] == 8'h99) ||
                                               (rand_mode && $urandom_range(0, 4) == 0);
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // requesters
    initial begin : requesters
        logic [N-1:0] gnt;
        s_arp_request_valid = '0; s_arp_request_ip = '0; s_arp_response_ready = '0;
        forever begin
            @(negedge clk);
            gnt = s_arp_request_ready & s_arp_request_valid;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    s_arp_request_valid[k]  = 0;
                    s_arp_response_ready[k] = 0;
                end else begin
                    if (gnt[k]) s_arp_request_valid[k] = 0;
                    if (pend_req[k] && !s_arp_request_valid[k]) begin
                        s_arp_request_valid[k]    = 1;
                        s_arp_request_ip[k*32 +: 32] = pend_ip[k];
                        pend_req[k]               = 0;
                    end else if (rand_mode) begin
                        if (!s_arp_request_valid[k] && $urandom_range(0, 3) == 0) begin
                            s_arp_request_valid[k]    = 1;
                            s_arp_request_ip[k*32 +: 32] = $urandom;
                        end else if (s_arp_request_valid[k] && !gnt[k] && $urandom_range(0, 9) == 0) begin
                            s_arp_request_valid[k] = 0;
                        end
                    end
                    if (rand_mode) begin
                        s_arp_response_ready[k] = ($urandom_range(0, 2) != 0);
                    end else if (s_arp_response_valid[k] && rsp_hold[k] > 0) begin
                        s_arp_response_ready[k] = 0;
                        rsp_hold[k]--;
                    end else begin
                        s_arp_response_ready[k] = 1;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        req_log.delete(); rsp_vec_log.delete(); rsp_mac_log.delete(); rsp_err_log.delete();
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int i = 0;
        while (rsp_vec_log.size() < n && i < budget) begin
            @(negedge clk); #1; i++;
        end
        chk("wait_rsp_count", rsp_vec_log.size(), n);
    endtask

    task automatic wait_for(input string nm, input int sel, input int budget);
        int i = 0;
        bit hit = 0;
        while (!hit && i < budget) begin
            case (sel)
                0: hit = (s_arp_request_ready != 0);
                1: hit = m_arp_request_valid;
                2: hit = m_arp_response_ready;
                3: hit = s_arp_response_valid[1];
                default: hit = 1;
            endcase
            if (!hit) begin @(negedge clk); #1; i++; end
        end
        chk(nm, hit, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); #1;
        @(negedge clk); rst = 0;
    endtask

    task automatic post(input int k, input logic [31:0] ip);
        pend_ip[k]  = ip;
        pend_req[k] = 1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [N-1:0] one;
        one = 1;
        for (int k = 0; k < N; k++) begin rsp_hold[k] = 0; pend_req[k] = 0; pend_ip[k] = '0; end
        repeat (2) @(posedge clk);
        #1 cmp_en = 1;
        @(negedge clk); #1;
        chk("rst_s_req_ready", s_arp_request_ready, 0);
        chk("rst_s_rsp_valid", s_arp_response_valid, 0);
        chk("rst_m_req_valid", m_arp_request_valid, 0);
        chk("rst_m_rsp_ready", m_arp_response_ready, 0);
        chk("rst_m_req_ip", m_arp_request_ip, 0);
        chk("rst_mac", s_arp_response_mac, 0);
        chk("rst_grant", grant_idx, 0);
        rst = 0;

        // single request from requester 2
        clear_logs();
        core_fix_mac = 1; core_mac_val = 48'h5A5152535455; core_delay = 3;
        post(2, 32'hC0A80164);
        wait_for("t1_grant_seen", 0, 20);
        chk("t1_ready_onehot", s_arp_request_ready, 4'b0100);
        @(negedge clk); #1;
        chk("t1_grant_idx", grant_idx, 2);
        chk("t1_req_ip", m_arp_request_ip, 32'hC0A80164);
        wait_rsp(1, 50);
        chk("t1_rsp_vec", rsp_vec_log[0], 4'b0100);
        chk("t1_rsp_mac", rsp_mac_log[0], 48'h5A5152535455);
        chk("t1_rsp_err", rsp_err_log[0], 0);
        chk("t1_latency", svalid_rise_cyc - core_rsp_cyc, 1);
        core_fix_mac = 0;
        // pointer now 3: requesters 0 and 3 together must go 3 then 0
        post(0, 32'hC0A80A00); post(3, 32'hC0A80A03);
        wait_rsp(3, 100);
        chk("t1_rr_first", rsp_vec_log[1], 4'b1000);
        chk("t1_rr_second", rsp_vec_log[2], 4'b0001);

        // all four at once from pointer 0
        do_reset();
        clear_logs(); core_delay = 0;
        for (int k = 0; k < N; k++) post(k, 32'hC0A80101 + k);
        wait_rsp(4, 200);
        for (int k = 0; k < N; k++) begin
            chk("t2_req_ip_order", req_log[k], 32'hC0A80101 + k);
            chk("t2_rsp_route", rsp_vec_log[k], one << k);
            chk("t2_rsp_mac", rsp_mac_log[k], {16'h0200, 32'hC0A80101 + k});
        end

        // core backpressure
        clear_logs(); core_stall = 10;
        post(1, 32'hC0A80111);
        wait_for("t3_req_seen", 1, 20);
        post(3, 32'hC0A80133);
        for (int i = 0; i < 10; i++) begin
            chk("t3_req_valid", m_arp_request_valid, 1);
            chk("t3_req_ip", m_arp_request_ip, 32'hC0A80111);
            chk("t3_s_ready_zero", s_arp_request_ready, 0);
            @(negedge clk); #1;
        end
        wait_rsp(2, 100);
        chk("t3_rsp0", rsp_vec_log[0], 4'b0010);
        chk("t3_rsp1", rsp_vec_log[1], 4'b1000);

        // requester backpressure
        clear_logs(); rsp_hold[1] = 5;
        post(1, 32'hC0A80122);
        wait_for("t4_grant_seen", 0, 20);
        post(0, 32'hC0A80120);
        wait_for("t4_rsp_seen", 3, 50);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid", s_arp_response_valid, 4'b0010);
            chk("t4_rsp_mac", s_arp_response_mac, {16'h0200, 32'hC0A80122});
            chk("t4_m_rsp_ready", m_arp_response_ready, 0);
            chk("t4_no_grant", s_arp_request_ready, 0);
            @(negedge clk); #1;
        end
        wait_rsp(2, 100);
        chk("t4_next_owner", rsp_vec_log[1], 4'b0001);

        // error path
        clear_logs();
        post(2, 32'hC0A80299);
        wait_rsp(1, 50);
        chk("t5_err_vec", rsp_vec_log[0], 4'b0100);
        chk("t5_err", rsp_err_log[0], 1);

        // reset in the middle of WAIT
        core_delay = 20;
        post(0, 32'hC0A80300);
        wait_for("t6_wait_seen", 2, 30);
        @(negedge clk); #1;
        rst = 1;
        @(negedge clk); #1;
        chk("t6_s_req_ready", s_arp_request_ready, 0);
        chk("t6_s_rsp_valid", s_arp_response_valid, 0);
        chk("t6_m_req_valid", m_arp_request_valid, 0);
        chk("t6_m_rsp_ready", m_arp_response_ready, 0);
        chk("t6_m_req_ip", m_arp_request_ip, 0);
        chk("t6_mac", s_arp_response_mac, 0);
        chk("t6_err", s_arp_response_error, 0);
        chk("t6_grant", grant_idx, 0);
        rst = 0; core_delay = 2;
        clear_logs();
        post(1, 32'hC0A80301); post(3, 32'hC0A80303);
        wait_rsp(2, 100);
        chk("t6_rr_reset", rsp_vec_log[0], 4'b0010);

        // random traffic
        clear_logs();
        rand_mode = 1; core_delay = -1;
        repeat (3000) @(negedge clk);
        rand_mode = 0; core_delay = 1;
        begin
            int i = 0;
            bit quiet = 0;
            while (!quiet && i < 400) begin
                @(negedge clk); #1; i++;
                quiet = (s_arp_request_valid == 0) && !m_arp_request_valid &&
                        !m_arp_response_ready && (s_arp_response_valid == 0);
            end
            chk("drain_quiet", quiet, 1);
        end
        chk("random_activity", rsp_vec_log.size() > 50, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
